// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - serializes retiring stores and loads onto one data-memory port
// Store-to-load forwarding is compiled in when DMEM_LD_FWD_EN is defined.
module dmem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ret_stbuf,
  input  logic [ADDR_W-1:0] i_ret_stbuf_addr,
  input  logic [DATA_W-1:0] i_ret_stbuf_data,
  output logic              o_dmem_occupy,
  input  logic              i_ld_req,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [TAG_W-1:0]  i_ld_tag,
  output logic              o_ld_ack,
  input  logic              i_stbuf_addr_hit,
  input  logic [DATA_W-1:0] i_stbuf_rd_data,
  output logic              o_ld_done,
  output logic [DATA_W-1:0] o_ld_data,
  output logic [TAG_W-1:0]  o_ld_tag,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvld,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT} state_t;

  state_t            state, state_nxt;
  logic              fwd;
  logic              ld_miss_acc, ld_fwd_acc, st_acc;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

`ifdef DMEM_LD_FWD_EN
  assign fwd = i_stbuf_addr_hit;
`else
  assign fwd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A miss load wins over a retire; a forwarded load can share the cycle with one.
  always_comb begin
    state_nxt     = state;
    o_dmem_occupy = 1'b0;
    o_ld_ack      = 1'b0;
    ld_miss_acc   = 1'b0;
    ld_fwd_acc    = 1'b0;
    st_acc        = 1'b0;
    if (rst_n) begin
      o_dmem_occupy = (state != IDLE) || (i_ld_req && !i_stbuf_addr_hit);
      o_ld_ack      = (state == IDLE) && i_ld_req && (!i_stbuf_addr_hit || fwd);
    end
    case (state)
      IDLE: begin
        ld_miss_acc = o_ld_ack && !fwd;
        ld_fwd_acc  = o_ld_ack && fwd;
        st_acc      = i_ret_stbuf && !ld_miss_acc;
        if (ld_miss_acc)  state_nxt = LD_REQ;
        else if (st_acc)  state_nxt = ST_REQ;
      end
      ST_REQ:  if (i_mem_gnt)  state_nxt = IDLE;
      LD_REQ:  if (i_mem_gnt)  state_nxt = LD_WAIT;
      LD_WAIT: if (i_mem_rvld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_mem_req   = (state == ST_REQ) || (state == LD_REQ);
  assign o_mem_we    = (state == ST_REQ);
  assign o_mem_addr  = req_addr;
  assign o_mem_wdata = req_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_tag   <= '0;
      o_ld_done <= 1'b0;
      o_ld_data <= '0;
      o_ld_tag  <= '0;
    end else begin
      o_ld_done <= 1'b0;
      if (ld_miss_acc) begin
        req_addr <= i_ld_addr;
        req_tag  <= i_ld_tag;
      end else if (st_acc) begin
        req_addr  <= i_ret_stbuf_addr;
        req_wdata <= i_ret_stbuf_data;
      end
      if (ld_fwd_acc) begin
        o_ld_done <= 1'b1;
        o_ld_data <= i_stbuf_rd_data;
        o_ld_tag  <= i_ld_tag;
      end else if (state == LD_WAIT && i_mem_rvld) begin
        o_ld_done <= 1'b1;
        o_ld_data <= i_mem_rdata;
        o_ld_tag  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl with a transaction-level reference model
module tb_dmem_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
`ifdef DMEM_LD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_ret_stbuf = 1'b0;
  logic [ADDR_W-1:0] i_ret_stbuf_addr = '0;
  logic [DATA_W-1:0] i_ret_stbuf_data = '0;
  logic              o_dmem_occupy;
  logic              i_ld_req = 1'b0;
  logic [ADDR_W-1:0] i_ld_addr = '0;
  logic [TAG_W-1:0]  i_ld_tag = '0;
  logic              o_ld_ack;
  logic              i_stbuf_addr_hit = 1'b0;
  logic [DATA_W-1:0] i_stbuf_rd_data = '0;
  logic              o_ld_done;
  logic [DATA_W-1:0] o_ld_data;
  logic [TAG_W-1:0]  o_ld_tag;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_gnt = 1'b0;
  logic              i_mem_rvld = 1'b0;
  logic [DATA_W-1:0] i_mem_rdata = '0;

  dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ret_stbuf(i_ret_stbuf), .i_ret_stbuf_addr(i_ret_stbuf_addr), .i_ret_stbuf_data(i_ret_stbuf_data),
    .o_dmem_occupy(o_dmem_occupy),
    .i_ld_req(i_ld_req), .i_ld_addr(i_ld_addr), .i_ld_tag(i_ld_tag), .o_ld_ack(o_ld_ack),
    .i_stbuf_addr_hit(i_stbuf_addr_hit), .i_stbuf_rd_data(i_stbuf_rd_data),
    .o_ld_done(o_ld_done), .o_ld_data(o_ld_data), .o_ld_tag(o_ld_tag),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvld(i_mem_rvld), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: at most one memory transaction outstanding, described as a record.
  bit                m_live = 1'b0;
  bit                m_busy, m_wr, m_granted, m_done, m_acked;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_ldata;
  logic [TAG_W-1:0]  m_tag, m_ltag;

  always @(posedge clk) begin
    bit hit_fwd;
    hit_fwd = FWD && i_stbuf_addr_hit;
    m_acked = rst_n && !m_busy && i_ld_req && (!i_stbuf_addr_hit || hit_fwd);
    m_done  = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_wr = 0; m_granted = 0;
      m_addr = '0; m_wdata = '0; m_tag = '0; m_ldata = '0; m_ltag = '0;
    end else if (m_busy) begin
      if (!m_granted && i_mem_gnt) begin
        if (m_wr) m_busy = 0;
        else      m_granted = 1;
      end else if (m_granted && i_mem_rvld) begin
        m_done = 1; m_ldata = i_mem_rdata; m_ltag = m_tag; m_busy = 0;
      end
    end else if (m_acked && !hit_fwd) begin
      m_busy = 1; m_wr = 0; m_granted = 0; m_addr = i_ld_addr; m_tag = i_ld_tag;
    end else begin
      if (m_acked) begin
        m_done = 1; m_ldata = i_stbuf_rd_data; m_ltag = i_ld_tag;
      end
      if (i_ret_stbuf) begin
        m_busy = 1; m_wr = 1; m_granted = 0; m_addr = i_ret_stbuf_addr; m_wdata = i_ret_stbuf_data;
      end
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    bit e_ack, e_occ, e_req;
    if (m_live) begin
      e_ack = rst_n && !m_busy && i_ld_req && (!i_stbuf_addr_hit || FWD);
      e_occ = rst_n && (m_busy || (i_ld_req && !i_stbuf_addr_hit));
      e_req = m_busy && !m_granted;
      check("model ld_ack", o_ld_ack, e_ack);
      check("model occupy", o_dmem_occupy, e_occ);
      check("model mem_req", o_mem_req, e_req);
      check("model mem_we", o_mem_we, m_busy && m_wr);
      check("model ld_done", o_ld_done, m_done);
      check("model ld_data", o_ld_data, m_ldata);
      check("model ld_tag", o_ld_tag, m_ltag);
      if (e_req) check("model mem_addr", o_mem_addr, m_addr);
      if (e_req && m_wr) check("model mem_wdata", o_mem_wdata, m_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i_ret_stbuf = 0; i_ld_req = 0; i_stbuf_addr_hit = 0; i_mem_gnt = 0; i_mem_rvld = 0;
  endtask

  task automatic random_phase(input int cycles);
    bit exp_occ;
    for (int c = 0; c < cycles; c++) begin
      tick();
      rst_n = (($urandom % 300) != 0);
      if (!rst_n || (i_ld_req && m_acked)) i_ld_req = 0;
      if (rst_n && !i_ld_req && ($urandom % 3 == 0)) begin
        i_ld_req = 1; i_ld_addr = $urandom; i_ld_tag = TAG_W'($urandom);
      end
      i_stbuf_addr_hit = ($urandom % 3 == 0);
      i_stbuf_rd_data  = $urandom;
      exp_occ = m_busy || (i_ld_req && !i_stbuf_addr_hit);
      i_ret_stbuf = rst_n && !exp_occ && ($urandom % 2 == 0);
      i_ret_stbuf_addr = $urandom;
      i_ret_stbuf_data = $urandom;
      i_mem_gnt  = ($urandom % 2 == 0);
      i_mem_rvld = (m_busy && m_granted) ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
      i_mem_rdata = $urandom;
    end
  endtask

  initial begin
    quiet();
    rst_n = 0;
    repeat (2) tick();
    @(negedge clk);
    check("reset occupy", o_dmem_occupy, 0);
    check("reset mem_req", o_mem_req, 0);
    check("reset ld_done", o_ld_done, 0);
    check("reset mem_addr", o_mem_addr, 0);
    tick(); rst_n = 1;

    // store retire, grant on the third request cycle
    i_ret_stbuf = 1; i_ret_stbuf_addr = 32'h100; i_ret_stbuf_data = 32'hDEADBEEF;
    tick(); i_ret_stbuf = 0;
    for (int k = 0; k < 3; k++) begin
      i_mem_gnt = (k == 2);
      @(negedge clk);
      check("st mem_req", o_mem_req, 1);
      check("st mem_we", o_mem_we, 1);
      check("st mem_addr", o_mem_addr, 32'h100);
      check("st mem_wdata", o_mem_wdata, 32'hDEADBEEF);
      check("st occupy", o_dmem_occupy, 1);
      tick();
    end
    i_mem_gnt = 0;
    @(negedge clk);
    check("st idle mem_req", o_mem_req, 0);
    check("st idle occupy", o_dmem_occupy, 0);

    // load miss, immediate grant, read data two cycles later
    tick(); i_ld_req = 1; i_ld_addr = 32'h200; i_ld_tag = 4'd3;
    @(negedge clk);
    check("ld ack", o_ld_ack, 1);
    check("ld occupy", o_dmem_occupy, 1);
    tick(); i_ld_req = 0; i_mem_gnt = 1;
    @(negedge clk);
    check("ld mem_req", o_mem_req, 1);
    check("ld mem_we", o_mem_we, 0);
    check("ld mem_addr", o_mem_addr, 32'h200);
    tick(); i_mem_gnt = 0;
    tick(); i_mem_rvld = 1; i_mem_rdata = 32'h12345678;
    tick(); i_mem_rvld = 0;
    @(negedge clk);
    check("ld done", o_ld_done, 1);
    check("ld data", o_ld_data, 32'h12345678);
    check("ld tag", o_ld_tag, 3);
    tick();
    @(negedge clk);
    check("ld done pulse", o_ld_done, 0);
    check("ld data hold", o_ld_data, 32'h12345678);

`ifdef DMEM_LD_FWD_EN
    tick(); i_ld_req = 1; i_ld_addr = 32'h300; i_ld_tag = 4'd5;
    i_stbuf_addr_hit = 1; i_stbuf_rd_data = 32'hCAFEF00D;
    @(negedge clk);
    check("fwd ack", o_ld_ack, 1);
    check("fwd occupy", o_dmem_occupy, 0);
    tick(); i_ld_req = 0; i_stbuf_addr_hit = 0;
    @(negedge clk);
    check("fwd done", o_ld_done, 1);
    check("fwd data", o_ld_data, 32'hCAFEF00D);
    check("fwd tag", o_ld_tag, 5);
    check("fwd mem_req", o_mem_req, 0);
`else
    tick(); i_ld_req = 1; i_ld_addr = 32'h400; i_ld_tag = 4'd9; i_stbuf_addr_hit = 1;
    for (int k = 0; k < 4; k++) begin
      i_ret_stbuf = (k % 2 == 0); i_ret_stbuf_addr = 32'h500 + k; i_ret_stbuf_data = 32'hA5A50000 + k;
      i_mem_gnt = (k % 2 == 1);
      @(negedge clk);
      check("nofwd ack held", o_ld_ack, 0);
      if (k % 2 == 0) check("nofwd occupy", o_dmem_occupy, 0);
      else check("nofwd st addr", o_mem_addr, 32'h500 + k - 1);
      tick();
    end
    i_ret_stbuf = 0; i_mem_gnt = 0; i_stbuf_addr_hit = 0;
    @(negedge clk);
    check("nofwd ack", o_ld_ack, 1);
    tick(); i_ld_req = 0; i_mem_gnt = 1;
    @(negedge clk);
    check("nofwd mem read", o_mem_req && !o_mem_we, 1);
    check("nofwd mem_addr", o_mem_addr, 32'h400);
    tick(); i_mem_gnt = 0; i_mem_rvld = 1; i_mem_rdata = 32'h0BADF00D;
    tick(); i_mem_rvld = 0;
    @(negedge clk);
    check("nofwd done", o_ld_done, 1);
    check("nofwd tag", o_ld_tag, 9);
`endif

    // miss load beats a store that wants to retire in the same cycle
    tick(); i_ld_req = 1; i_ld_addr = 32'h600; i_ld_tag = 4'd2;
    @(negedge clk);
    check("prio occupy", o_dmem_occupy, 1);
    check("prio ack", o_ld_ack, 1);
    tick(); i_ld_req = 0; i_mem_gnt = 1;
    tick(); i_mem_gnt = 0; i_mem_rvld = 1; i_mem_rdata = 32'h11112222;
    tick(); i_mem_rvld = 0;
    @(negedge clk);
    check("prio done", o_ld_done, 1);
    check("prio free", o_dmem_occupy, 0);
    tick(); i_ret_stbuf = 1; i_ret_stbuf_addr = 32'h610; i_ret_stbuf_data = 32'h33334444;
    tick(); i_ret_stbuf = 0;
    @(negedge clk);
    check("prio st addr", o_mem_addr, 32'h610);
    tick(); i_mem_gnt = 1;
    tick(); i_mem_gnt = 0;

    // reset while waiting for read data
    tick(); i_ld_req = 1; i_ld_addr = 32'h700; i_ld_tag = 4'd7;
    tick(); i_ld_req = 0; i_mem_gnt = 1;
    tick(); i_mem_gnt = 0;
    @(negedge clk);
    check("rst pre occupy", o_dmem_occupy, 1);
    tick(); rst_n = 0;
    tick();
    @(negedge clk);
    check("rst occupy", o_dmem_occupy, 0);
    check("rst ack", o_ld_ack, 0);
    check("rst done", o_ld_done, 0);
    check("rst data", o_ld_data, 0);
    check("rst tag", o_ld_tag, 0);
    check("rst mem_req", o_mem_req, 0);
    check("rst mem_we", o_mem_we, 0);
    check("rst mem_addr", o_mem_addr, 0);
    check("rst mem_wdata", o_mem_wdata, 0);
    tick(); rst_n = 1; i_mem_rvld = 1; i_mem_rdata = 32'hFFFF0000;
    tick(); i_mem_rvld = 0;
    @(negedge clk);
    check("late rvld done", o_ld_done, 0);
    check("late rvld mem_req", o_mem_req, 0);

    random_phase(3000);
    tick(); quiet();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
